tusca_tx_arbiter: RTL
=====================

TUSCA_TX_ARBITER -- requirements
Module: tusca_tx_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: req  in  3  per-requester frame request (0=medida, 1=config, 2=erro), level, held until its done.
REQ-004 SHALL have: dados0, dados1, dados2  in  32 each  requester payload, byte0 = [31:24].
REQ-005 SHALL have: nbytes0, nbytes1, nbytes2  in  3 each  payload length in bytes, 1..4.
REQ-006 SHALL have: grant  out  3  one-hot, 1-cycle pulse when a requester's payload is sampled.
REQ-007 SHALL have: done  out  3  one-hot, 1-cycle pulse when that requester's frame is fully transmitted.
REQ-008 SHALL have: uart_partida  out  1  1-cycle byte-start pulse to the serial transmitter.
REQ-009 SHALL have: uart_dados  out  8  byte for the transmitter, stable from uart_partida until uart_pronto.
REQ-010 SHALL have: uart_pronto  in  1  1-cycle pulse when the transmitter finishes a byte.
REQ-011 SHALL have: ocupado  out  1  high in every state except INICIAL and ARBITRA.
REQ-012 SHALL have: db_estado  out  4  current state encoding.

Function
REQ-013 SHALL implement states INICIAL=0, ARBITRA=1, CARREGA=2, ENVIA_BYTE=3, ESPERA_BYTE=4, PROXIMO=5, ENVIA_CHECKSUM=6, ESPERA_CHECKSUM=7, FIM=8; undefined encodings -> INICIAL.
REQ-014 SHALL transition INICIAL -> ARBITRA unconditionally after reset release.
REQ-015 SHALL, in ARBITRA, remain while req==0; otherwise select one requester round-robin and go to CARREGA.
REQ-016 Round-robin SHALL search starting at the requester after the last granted; after reset, search order SHALL be 0,1,2.
REQ-017 SHALL, in CARREGA, pulse grant for the winner, latch its dados/nbytes, and clear the byte index and checksum.
REQ-018 SHALL treat nbytes 0 as 1 and nbytes 5..7 as 4.
REQ-019 SHALL, in ENVIA_BYTE, drive uart_dados = latched byte[index] and pulse uart_partida, then go to ESPERA_BYTE.
REQ-020 Latency: uart_partida SHALL assert exactly 2 cycles after ARBITRA first sees a nonzero req.
REQ-021 SHALL hold ESPERA_BYTE until uart_pronto, then go to PROXIMO.
REQ-022 SHALL, in PROXIMO, XOR the sent byte into the checksum and increment the index; if index < length go to ENVIA_BYTE, else ENVIA_CHECKSUM (macro on) or FIM (macro off).
REQ-023 SHALL ignore uart_pronto in all states other than ESPERA_BYTE and ESPERA_CHECKSUM.
REQ-024 SHALL, in FIM, pulse done for the granted requester and return to ARBITRA.
REQ-025 A requester dropping req mid-frame SHALL NOT abort the frame; done SHALL still pulse.
REQ-026 Changes to dados/nbytes after grant SHALL NOT affect the frame in flight.
REQ-027 Requests arriving while ocupado SHALL wait; they SHALL be arbitrated in the next ARBITRA cycle.

Reset
REQ-028 Reset low SHALL force INICIAL immediately, including mid-frame, with no done pulse for the aborted frame.
REQ-029 Reset SHALL clear grant, done, uart_partida, uart_dados, ocupado, index, checksum, latched payload and the round-robin pointer (next search order 0,1,2); db_estado SHALL read 0.

Configuration
REQ-030 With TUSCA_TX_CHECKSUM_EN defined, ENVIA_CHECKSUM SHALL drive uart_dados = XOR of all payload bytes and pulse uart_partida; ESPERA_CHECKSUM SHALL wait for uart_pronto and then go to FIM.
REQ-031 Without TUSCA_TX_CHECKSUM_EN, states 6 and 7 SHALL be unreachable and map to INICIAL; a frame SHALL be exactly the payload bytes.

Structure
REQ-032 State encodings, requester indices (MEDIDA=0, CONFIG=1, ERRO=2) and the maximum length of 4 SHALL live in shared package tusca_pkg.
REQ-033 The round-robin grant logic SHALL be sub-module tusca_rr_arbiter (inputs req[2:0] and the last granted index; output a one-hot winner).

Verification
REQ-034 req=001, dados0=0x4D1E2A00, nbytes0=3 -> bytes 4D,1E,2A; checksum 79 if macro on; done=001 once.
REQ-035 req=111 held continuously from reset -> grant order 001,010,100,001.
REQ-036 nbytes1=0, dados1=0x43000000 -> exactly one byte 0x43; nbytes2=7 -> exactly 4 bytes.
REQ-037 reset low during the 2nd ESPERA_BYTE of a 4-byte frame -> db_estado=0, no done, next grant follows order 0,1,2.
REQ-038 uart_pronto pulsed in ARBITRA, then dados0 changed after grant -> pulse ignored; transmitted bytes equal the sampled payload.

Source files
------------

// File: rtl/tusca_pkg.sv
// Shared definitions for the Tusca transmit arbiter.
// Contents: state encodings, requester indices, payload width and length
// limits, the latched payload struct, and small byte/index helper functions.
package tusca_pkg;

  localparam int unsigned N_REQ   = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned MAX_LEN = 4;

  // Requester indices
  localparam logic [SEL_W-1:0] MEDIDA = SEL_W'(0);
  localparam logic [SEL_W-1:0] CONFIG = SEL_W'(1);
  localparam logic [SEL_W-1:0] ERRO   = SEL_W'(2);

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    ARBITRA         = 4'd1,
    CARREGA         = 4'd2,
    ENVIA_BYTE      = 4'd3,
    ESPERA_BYTE     = 4'd4,
    PROXIMO         = 4'd5,
    ENVIA_CHECKSUM  = 4'd6,
    ESPERA_CHECKSUM = 4'd7,
    FIM             = 4'd8
  } estado_t;

  // Payload captured from the winning requester
  typedef struct packed {
    logic [DATA_W-1:0] dados;
    logic [LEN_W-1:0]  len;
  } payload_t;

  // Lengths outside 1..MAX_LEN are saturated into range
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    logic [LEN_W-1:0] r;
    r = n;
    if (n == '0) r = LEN_W'(1);
    else if (n > LEN_W'(MAX_LEN)) r = LEN_W'(MAX_LEN);
    return r;
  endfunction

  // Byte 0 is the most significant byte of the word
  function automatic logic [BYTE_W-1:0] byte_at(input logic [DATA_W-1:0] d,
                                                input logic [LEN_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      LEN_W'(0): b = d[31:24];
      LEN_W'(1): b = d[23:16];
      LEN_W'(2): b = d[15:8];
      default:   b = d[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] i;
    if (oh[2])      i = ERRO;
    else if (oh[1]) i = CONFIG;
    else            i = MEDIDA;
    return i;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/tusca_rr_arbiter.sv
// Round-robin winner selection for the three Tusca requesters.
// Ports:
//   req      in  3  pending requests
//   last     in  2  index of the most recently granted requester
//   winner_c out 3  one-hot winner (combinational, zero when req is zero)
// The search starts at the requester after 'last' and wraps around.
module tusca_rr_arbiter
  import tusca_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [N_REQ-1:0] winner_c
);

  logic [SEL_W-1:0] pos;

  // First requesting index in the order last+1, last+2, last+3 (mod 3)
  always_comb begin
    winner_c = '0;
    pos      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = SEL_W'((32'(last) + k) % N_REQ);
      if ((winner_c == '0) && req[pos]) winner_c[pos] = 1'b1;
    end
  end

endmodule

// File: rtl/tusca_tx_arbiter.sv
// Tusca transmit arbiter: picks one of three frame requesters round-robin,
// latches its payload and feeds it byte by byte to a serial transmitter,
// optionally followed by an XOR checksum byte.
// Build option: define TUSCA_TX_CHECKSUM_EN to append the checksum byte.
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   req[2:0]        in   level requests (0=medida, 1=config, 2=erro)
//   dados0..2       in   32-bit payloads, byte0 = [31:24]
//   nbytes0..2      in   payload lengths (clamped to 1..4)
//   grant[2:0]      out  one-hot pulse when a payload is sampled
//   done[2:0]       out  one-hot pulse when a frame completes
//   uart_partida    out  byte-start pulse to the transmitter
//   uart_dados[7:0] out  byte to transmit, held until uart_pronto
//   uart_pronto     in   transmitter byte-finished pulse
//   ocupado         out  high outside INICIAL/ARBITRA
//   db_estado[3:0]  out  current state encoding
module tusca_tx_arbiter
  import tusca_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [31:0]       dados0,
  input  logic [31:0]       dados1,
  input  logic [31:0]       dados2,
  input  logic [2:0]        nbytes0,
  input  logic [2:0]        nbytes1,
  input  logic [2:0]        nbytes2,
  output logic [2:0]        grant,
  output logic [2:0]        done,
  output logic              uart_partida,
  output logic [7:0]        uart_dados,
  input  logic              uart_pronto,
  output logic              ocupado,
  output logic [3:0]        db_estado
);

  estado_t           state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  payload_t          payload_q, payload_d;
  logic [LEN_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [BYTE_W-1:0] cks_q, cks_d;
  logic [N_REQ-1:0]  grant_d, done_d;
  logic              partida_d;
  logic [BYTE_W-1:0] dados_d;
  logic              ocupado_d;

  logic [N_REQ-1:0]  winner_c;
  logic [SEL_W-1:0]  win_idx_c;
  payload_t          cand_c;

  tusca_rr_arbiter u_rr (
    .req      (req),
    .last     (sel_q),
    .winner_c (winner_c)
  );

  // Payload of the current round-robin winner
  always_comb begin
    win_idx_c = onehot_to_idx(winner_c);
    case (win_idx_c)
      CONFIG:  cand_c = '{dados: dados1, len: clamp_len(nbytes1)};
      ERRO:    cand_c = '{dados: dados2, len: clamp_len(nbytes2)};
      default: cand_c = '{dados: dados0, len: clamp_len(nbytes0)};
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // Next state and next values of all registered outputs/datapath
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    cks_d     = cks_q;
    grant_d   = '0;
    done_d    = '0;
    partida_d = 1'b0;
    dados_d   = uart_dados;
    idx_nxt   = idx_q + LEN_W'(1);

    case (state_q)
      INICIAL: state_d = ARBITRA;

      // Payload is captured on the same edge that raises grant, so the
      // requester may change it as soon as grant is visible.
      ARBITRA: begin
        if (req != '0) begin
          state_d   = CARREGA;
          sel_d     = win_idx_c;
          grant_d   = winner_c;
          payload_d = cand_c;
        end
      end

      CARREGA: begin
        idx_d     = '0;
        cks_d     = '0;
        dados_d   = byte_at(payload_q.dados, LEN_W'(0));
        partida_d = 1'b1;
        state_d   = ENVIA_BYTE;
      end

      ENVIA_BYTE: state_d = ESPERA_BYTE;

      ESPERA_BYTE: begin
        if (uart_pronto) state_d = PROXIMO;
      end

      PROXIMO: begin
        cks_d = cks_q ^ uart_dados;
        idx_d = idx_nxt;
        if (idx_nxt < payload_q.len) begin
          dados_d   = byte_at(payload_q.dados, idx_nxt);
          partida_d = 1'b1;
          state_d   = ENVIA_BYTE;
        end else begin
`ifdef TUSCA_TX_CHECKSUM_EN
          dados_d   = cks_q ^ uart_dados;
          partida_d = 1'b1;
          state_d   = ENVIA_CHECKSUM;
`else
          done_d    = idx_to_onehot(sel_q);
          state_d   = FIM;
`endif
        end
      end

`ifdef TUSCA_TX_CHECKSUM_EN
      ENVIA_CHECKSUM: state_d = ESPERA_CHECKSUM;

      ESPERA_CHECKSUM: begin
        if (uart_pronto) begin
          done_d  = idx_to_onehot(sel_q);
          state_d = FIM;
        end
      end
`endif

      FIM: state_d = ARBITRA;

      default: state_d = INICIAL;
    endcase

    ocupado_d = !((state_d == INICIAL) || (state_d == ARBITRA));
  end

  // Datapath and output registers; sel resets to ERRO so the first search is 0,1,2
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q        <= ERRO;
      payload_q    <= '0;
      idx_q        <= '0;
      cks_q        <= '0;
      grant        <= '0;
      done         <= '0;
      uart_partida <= 1'b0;
      uart_dados   <= '0;
      ocupado      <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      payload_q    <= payload_d;
      idx_q        <= idx_d;
      cks_q        <= cks_d;
      grant        <= grant_d;
      done         <= done_d;
      uart_partida <= partida_d;
      uart_dados   <= dados_d;
      ocupado      <= ocupado_d;
    end
  end

  assign db_estado = state_q;

endmodule
